// File: rtl/sum32_accumulator.sv
// sum32_accumulator: accumulates N signed 32-bit sums per burst with sticky overflow, wrap or saturate
module sum32_accumulator #(
  parameter int N   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] C,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] ACC,
  output logic        OVF,
  output logic [7:0]  CNT
);
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic [7:0] LAST = 8'(N - 1);
  state_t      state;
  logic [31:0] s;
  logic        v;
  logic [31:0] nxt;
  assign IN_READY  = (state == ACCUM);
  assign OUT_VALID = (state == HOLD);
  // signed step: overflow when operands agree in sign but the sum does not
  always_comb begin
    s   = ACC + C;
    v   = (ACC[31] == C[31]) && (s[31] != ACC[31]);
    nxt = (SAT && v) ? (C[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s;
  end
  // burst handshake, accumulation and result hold
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ACCUM;
      ACC   <= '0;
      OVF   <= 1'b0;
      CNT   <= '0;
    end else if (state == ACCUM && IN_VALID) begin
      ACC   <= (CNT == 8'd0) ? C : nxt;
      OVF   <= (CNT == 8'd0) ? 1'b0 : (OVF | v);
      CNT   <= CNT + 8'd1;
      state <= (CNT == LAST) ? HOLD : ACCUM;
    end else if (state == HOLD && OUT_READY) begin
      state <= ACCUM;
      CNT   <= '0;
    end
  end
endmodule

// File: tb/tb_sum32_accumulator.sv
// tb_sum32_accumulator: wrap and saturate instances driven together, checked against an arithmetic model
module tb_sum32_accumulator;
  localparam int N = 4;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [31:0] C = '0;
  logic        OUT_READY = 1'b0;
  logic        ir0, ov0, ovf0, ir1, ov1, ovf1;
  logic [31:0] acc0, acc1;
  logic [7:0]  cnt0, cnt1;
  int tests = 0;
  int fails = 0;
  bit          m_hold;
  int          m_cnt;
  logic [31:0] m_acc [2];
  bit          m_ovf [2];

  always #5 CLK = ~CLK;

  sum32_accumulator #(.N(N), .SAT(1'b0)) dut_wrap (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir0), .C(C),
    .OUT_VALID(ov0), .OUT_READY(OUT_READY), .ACC(acc0), .OVF(ovf0), .CNT(cnt0)
  );
  sum32_accumulator #(.N(N), .SAT(1'b1)) dut_sat (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir1), .C(C),
    .OUT_VALID(ov1), .OUT_READY(OUT_READY), .ACC(acc1), .OVF(ovf1), .CNT(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic add(input int k, input logic [31:0] c);
    longint e;
    bit     o;
    e = longint'($signed(m_acc[k])) + longint'($signed(c));
    o = (e > 64'sd2147483647) || (e < -64'sd2147483648);
    if (k == 1 && o) m_acc[k] = (e > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else m_acc[k] = e[31:0];
    m_ovf[k] = m_ovf[k] | o;
  endtask

  task automatic step(input bit r, input bit iv, input logic [31:0] c, input bit ordy);
    RST = r; IN_VALID = iv; C = c; OUT_READY = ordy;
    @(posedge CLK);
    if (r) begin
      m_hold = 0; m_cnt = 0; m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    end else if (!m_hold && iv) begin
      if (m_cnt == 0) begin
        m_acc[0] = c; m_acc[1] = c; m_ovf[0] = 0; m_ovf[1] = 0;
      end else begin
        add(0, c); add(1, c);
      end
      m_cnt++;
      if (m_cnt == N) m_hold = 1;
    end else if (m_hold && ordy) begin
      m_hold = 0; m_cnt = 0;
    end
    #1;
    chk("in_ready_wrap", 32'(ir0), 32'(!m_hold));
    chk("out_valid_wrap", 32'(ov0), 32'(m_hold));
    chk("cnt_wrap", 32'(cnt0), 32'(m_cnt));
    chk("acc_wrap", acc0, m_acc[0]);
    chk("ovf_wrap", 32'(ovf0), 32'(m_ovf[0]));
    chk("in_ready_sat", 32'(ir1), 32'(!m_hold));
    chk("out_valid_sat", 32'(ov1), 32'(m_hold));
    chk("cnt_sat", 32'(cnt1), 32'(m_cnt));
    chk("acc_sat", acc1, m_acc[1]);
    chk("ovf_sat", 32'(ovf1), 32'(m_ovf[1]));
  endtask

  logic [31:0] edge_vals [4];

  initial begin
    edge_vals[0] = 32'h7FFF_FFFF; edge_vals[1] = 32'h8000_0000;
    edge_vals[2] = 32'h4000_0000; edge_vals[3] = 32'hC000_0000;
    step(1, 0, 0, 0);
    step(1, 1, 32'd77, 1);
    chk("reset_cnt", 32'(cnt0), 0);
    chk("reset_in_ready", 32'(ir0), 1);
    // basic burst
    step(0, 1, 32'd10, 1); step(0, 1, 32'd20, 1); step(0, 1, 32'd30, 1); step(0, 1, 32'd40, 1);
    chk("basic_acc", acc0, 32'd100);
    chk("basic_cnt", 32'(cnt0), 32'd4);
    chk("basic_valid", 32'(ov0), 1);
    step(0, 1, 32'd555, 1);
    chk("basic_back_ready", 32'(ir0), 1);
    // signed burst
    step(0, 1, -32'sd5, 0); step(0, 1, -32'sd10, 0); step(0, 1, -32'sd100, 0); step(0, 1, 32'd50, 0);
    chk("signed_acc", acc0, 32'hFFFF_FFBF);
    chk("signed_ovf", 32'(ovf0), 0);
    step(0, 0, 0, 1);
    // overflow positive
    step(0, 1, 32'h7FFF_FFFF, 0); step(0, 1, 32'd1, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    chk("ovf_pos_wrap_acc", acc0, 32'h8000_0000);
    chk("ovf_pos_wrap_flag", 32'(ovf0), 1);
    chk("ovf_pos_sat_acc", acc1, 32'h7FFF_FFFF);
    chk("ovf_pos_sat_flag", 32'(ovf1), 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'd1, 0); step(0, 1, 32'd1, 0); step(0, 1, 32'd1, 0); step(0, 1, 32'd1, 0);
    chk("sticky_cleared_acc", acc0, 32'd4);
    chk("sticky_cleared_flag", 32'(ovf0), 0);
    step(0, 0, 0, 1);
    // overflow negative
    step(0, 1, 32'h8000_0000, 0); step(0, 1, 32'hFFFF_FFFF, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    chk("ovf_neg_sat_acc", acc1, 32'h8000_0000);
    chk("ovf_neg_sat_flag", 32'(ovf1), 1);
    chk("ovf_neg_wrap_acc", acc0, 32'h7FFF_FFFF);
    step(0, 0, 0, 1);
    // gaps and backpressure
    step(0, 1, 32'd1, 0); step(0, 0, 32'd9, 0); step(0, 1, 32'd2, 0); step(0, 0, 32'd9, 0);
    step(0, 1, 32'd3, 0); step(0, 0, 32'd9, 0); step(0, 1, 32'd4, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'd99, 0);
      chk("bp_in_ready", 32'(ir0), 0);
      chk("bp_acc", acc0, 32'd10);
      chk("bp_valid", 32'(ov0), 1);
    end
    step(0, 1, 32'd99, 1);
    step(0, 1, 32'd99, 1);
    chk("fresh_acc", acc0, 32'd99);
    chk("fresh_cnt", 32'(cnt0), 1);
    step(0, 1, 32'd1, 1); step(0, 1, 32'd1, 1); step(0, 1, 32'd1, 1);
    step(0, 0, 0, 1);
    // reset mid-burst
    step(0, 1, 32'd7, 0); step(0, 1, 32'd8, 0);
    step(1, 1, 32'd500, 0);
    chk("rst_mid_cnt", 32'(cnt0), 0);
    chk("rst_mid_acc", acc0, 0);
    chk("rst_mid_valid", 32'(ov0), 0);
    step(0, 1, 32'd1, 0); step(0, 1, 32'd1, 0); step(0, 1, 32'd1, 0); step(0, 1, 32'd1, 0);
    chk("post_rst_acc", acc0, 32'd4);
    step(0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0 ? edge_vals[$urandom_range(0, 3)] : 32'($urandom),
           $urandom_range(0, 1) == 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sum32_accumulator.md
# sum32_accumulator

Downstream consumer of the 32-bit signed adder stage. It takes the adder's sum word `C` through a valid/ready handshake, accumulates `N` consecutive sums into a 32-bit two's-complement total, and tracks signed overflow (sticky per burst). It presents the finished total to the next stage through a second valid/ready handshake. Accumulation either wraps or saturates, selected by parameter.

## Interface
- `N`, default 4: sums per burst, legal range 2..255.
- `SAT`, default 0: 0 = two's-complement wrap; 1 = clamp each step to 0x7FFFFFFF / 0x80000000.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `IN_VALID` in 1: `C` holds a valid sum.
- `IN_READY` out 1: block accepts a sum this cycle.
- `C` in 32: signed sum from the adder stage.
- `OUT_VALID` out 1: `ACC`/`OVF` hold a finished burst.
- `OUT_READY` in 1: downstream takes the result.
- `ACC` out 32: signed running/final total.
- `OVF` out 1: at least one signed overflow occurred in the current burst.
- `CNT` out 8: sums accepted in the current burst.

## Operation
- One clock; reset is synchronous and active-high.
- States:
  - `ACCUM`: `IN_READY`=1, `OUT_VALID`=0.
  - `HOLD`: `IN_READY`=0, `OUT_VALID`=1.
  - `IN_READY` and `OUT_VALID` are decoded directly from the state register, with no combinational path from the inputs.
- Accept condition: `IN_VALID && IN_READY` at a rising edge.
- On the first accept of a burst (`CNT`=0):
  - `ACC` <= `C`
  - `OVF` <= 0
  - `CNT` <= 1
- On each later accept:
  - Compute `s = ACC + C`, 32-bit.
  - Overflow `v` = (`ACC[31]` == `C[31]`) && (`s[31]` != `ACC[31]`).
  - `ACC` <= `s` when `SAT`=0, or when `SAT`=1 and `v`=0.
  - When `SAT`=1 and `v`=1, `ACC` <= 0x7FFFFFFF if `C[31]`=0, else 0x80000000.
  - `OVF` <= `OVF | v`.
  - `CNT` <= `CNT`+1.
- `ACCUM` -> `HOLD` on the accept that brings `CNT` to `N`.
- While in `HOLD`:
  - `ACC`, `OVF` and `CNT` (= `N`) are frozen.
  - `C` and `IN_VALID` are ignored.
- `HOLD` -> `ACCUM` when `OUT_READY`=1.
  - `CNT` <= 0 on the same edge.
  - `ACC`/`OVF` keep their final values until the next first accept overwrites them.
- No bypass: a sum cannot be accepted in the same cycle the result is taken.
- `IN_VALID` low cycles (gaps) have no effect. `CNT`, `ACC` and `OVF` hold.
- Reset, applied in any state and at any `CNT`:
  - state = `ACCUM`; `ACC`=0, `OVF`=0, `CNT`=0.
  - `OUT_VALID`=0, `IN_READY`=1 from the first cycle after `RST` deasserts.
  - A sum presented in a cycle with `RST`=1 is not accepted.
  - Reset takes priority over an accept or an output transfer in the same cycle.

## Timing
- `OUT_VALID` rises one cycle after the edge that accepts the `N`th sum.
- Minimum burst period is `N`+1 cycles: `N` accepts plus one `HOLD` cycle with `OUT_READY`=1.
- Result is held indefinitely under backpressure (`OUT_READY`=0). No sum is lost or dropped.
- `ACC` updates on the same edge as the accept. The running total is visible during a burst but is only meaningful with `OUT_VALID`=1.
- All outputs are registered or decoded from state. No input-to-output combinational path.

## Test plan
- Basic burst (`N`=4, `SAT`=0): `C`=10, 20, 30, 40 on consecutive cycles with `OUT_READY`=1.
  - `OUT_VALID`=1 one cycle later, with `ACC`=100, `OVF`=0, `CNT`=4.
  - Back in `ACCUM` the next cycle.
- Signed burst: `C`=-5, -10, -100, 50.
  - `ACC`=0xFFFFFFBF (-65), `OVF`=0.
- Overflow, wrap mode: `C`=0x7FFFFFFF, 1, 0, 0.
  - `ACC`=0x80000000, `OVF`=1.
  - Next burst 1, 1, 1, 1 gives `ACC`=4, `OVF`=0 (sticky flag cleared per burst).
- Overflow, saturate mode (`SAT`=1): `C`=0x7FFFFFFF, 1, 0, 0 gives `ACC`=0x7FFFFFFF, `OVF`=1.
  - `C`=0x80000000, -1, 0, 0 gives `ACC`=0x80000000, `OVF`=1.
- Backpressure and gaps:
  - Burst 1, 2, 3, 4 with `IN_VALID` low on alternate cycles gives `ACC`=10.
  - Hold `OUT_READY`=0 for 3 cycles with `IN_VALID`=1 and `C`=99. Require `IN_READY`=0, and `ACC`=10 and `OUT_VALID`=1 stable throughout.
  - Release `OUT_READY`; the next burst starts fresh at `C`=99.
- Reset mid-burst: accept 7, 8, then assert `RST` for one cycle while `IN_VALID`=1, `C`=500.
  - Next cycle: `CNT`=0, `ACC`=0, `OVF`=0, `OUT_VALID`=0, `IN_READY`=1.
  - The 500 is not counted.
  - Burst 1, 1, 1, 1 afterward gives `ACC`=4.
